// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive controller.
package uart_pkg;

   typedef enum logic [2:0] {INIT, LOAD, READ, RUN, PEND} ctrl_state_t;

   localparam int unsigned UART_DEFAULT_BAUD = 115200;
   localparam int unsigned UART_HOLD_CYC     = 3;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Buffered byte stream from the receive controller to its consumer.
interface uart_rx_ctrl_if #(
   parameter int unsigned DATA_WDTH = 8
) ();

   logic [DATA_WDTH-1:0] M_DATAo;
   logic                 M_VALIDo;
   logic                 M_READYi;

   modport master (output M_DATAo, output M_VALIDo, input M_READYi);
   modport slave  (input M_DATAo, input M_VALIDo, output M_READYi);

endinterface

// File: rtl/uart_rx_fifo.sv
// Byte buffer for captured receiver data; the caller only pushes when space is guaranteed.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WDTH  = 8,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_push,
   input  logic                 i_pop,
   input  logic [DATA_WDTH-1:0] i_wdata,
   output logic [DATA_WDTH-1:0] o_rdata,
   output logic                 o_full,
   output logic                 o_empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [DATA_WDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_full  = (r_count == (AW+1)'(FIFO_DEPTH));
   assign o_empty = (r_count == '0);
   assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver configuration sequencer plus RX_DONE edge capture into a byte buffer.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WDTH    = 8,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned DEFAULT_BAUD = UART_DEFAULT_BAUD,
   parameter int unsigned HOLD_CYC     = UART_HOLD_CYC
) (
   input  logic                 CLKip,
   input  logic                 RSTNi,
   input  logic [31:0]          CFG_BAUDi,
   input  logic                 CFG_WEi,
   output logic                 CFG_BUSYo,
   output logic                 CFG_ERRo,
   input  logic                 RX_DONEi,
   input  logic                 RX_READYi,
   input  logic [DATA_WDTH-1:0] RX_DATAi,
   output logic [31:0]          BAUD_RATEo,
   output logic                 BAUD_WEo,
   output logic                 BAUD_RDo,
   uart_rx_ctrl_if.master       m_if,
   output logic                 OVFo,
   input  logic                 CLR_OVFi,
   output logic [15:0]          FRAME_CNTo
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

   ctrl_state_t          r_state, w_state_nxt;
   logic [7:0]           r_hold, w_hold_nxt;
   logic [31:0]          r_baud, w_baud_nxt;
   logic                 w_err_set;
   logic                 r_cfg_err;
   logic                 r_rx_done_q;
   logic                 r_ovf;
   logic [15:0]          r_frame_cnt;
   logic                 w_capture, w_pop, w_push, w_ovf_set;
   logic                 w_full, w_empty, w_valid;
   logic [DATA_WDTH-1:0] w_rdata;

   always_ff @(posedge CLKip or negedge RSTNi) begin
      if (!RSTNi) begin
         r_state <= INIT;
         r_hold  <= '0;
         r_baud  <= DEFAULT_BAUD;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_baud  <= w_baud_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = '0;
      w_baud_nxt  = r_baud;
      w_err_set   = 1'b0;
      unique case (r_state)
         INIT: w_state_nxt = LOAD;
         LOAD: begin
            if (r_hold == HOLD_LAST) w_state_nxt = READ;
            else                     w_hold_nxt  = r_hold + 8'd1;
         end
         READ: begin
            if (r_hold == HOLD_LAST) w_state_nxt = RUN;
            else                     w_hold_nxt  = r_hold + 8'd1;
         end
         RUN: begin
            if (CFG_WEi) begin
               if (CFG_BAUDi != '0) begin
                  w_baud_nxt  = CFG_BAUDi;
                  w_state_nxt = RX_READYi ? LOAD : PEND;
               end else begin
                  w_err_set = 1'b1;
               end
            end
         end
         PEND: if (RX_READYi) w_state_nxt = LOAD;
         default: w_state_nxt = INIT;
      endcase
   end

   // Full buffer accepts a capture only when a pop frees a slot in the same cycle.
   assign w_capture = RX_DONEi & ~r_rx_done_q;
   assign w_valid   = ~w_empty;
   assign w_pop     = w_valid & m_if.M_READYi;
   assign w_push    = w_capture & (~w_full | w_pop);
   assign w_ovf_set = w_capture & w_full & ~w_pop;

   always_ff @(posedge CLKip or negedge RSTNi) begin
      if (!RSTNi) begin
         r_rx_done_q <= 1'b0;
         r_cfg_err   <= 1'b0;
         r_ovf       <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_rx_done_q <= RX_DONEi;
         r_cfg_err   <= r_cfg_err | w_err_set;
         if (w_ovf_set)     r_ovf <= 1'b1;
         else if (CLR_OVFi) r_ovf <= 1'b0;
         if (w_push) r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   uart_rx_fifo #(
      .DATA_WDTH  (DATA_WDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (CLKip),
      .i_rst_n (RSTNi),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (RX_DATAi),
      .o_rdata (w_rdata),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign m_if.M_DATAo  = w_rdata;
   assign m_if.M_VALIDo = w_valid;
   assign CFG_BUSYo     = (r_state != RUN);
   assign CFG_ERRo      = r_cfg_err;
   assign BAUD_RATEo    = r_baud;
   assign BAUD_WEo      = (r_state == LOAD);
   assign BAUD_RDo      = (r_state == READ);
   assign OVFo          = r_ovf;
   assign FRAME_CNTo    = r_frame_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: config sequencing, byte stream, overflow and reset.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] cfg_baud = '0;
   logic        cfg_we = 1'b0;
   logic        cfg_busy, cfg_err;
   logic        rx_done = 1'b0;
   logic        rx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic [31:0] baud_rate;
   logic        baud_we, baud_rd;
   logic        ovf;
   logic        clr_ovf = 1'b0;
   logic [15:0] frame_cnt;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  exp_q[$];
   int          frame_exp = 0;
   logic        ovf_exp = 1'b0;

   uart_rx_ctrl_if #(.DATA_WDTH(8)) m_if ();

   uart_rx_ctrl #(
      .DATA_WDTH    (8),
      .FIFO_DEPTH   (DEPTH),
      .DEFAULT_BAUD (115200),
      .HOLD_CYC     (3)
   ) dut (
      .CLKip      (clk),
      .RSTNi      (rst_n),
      .CFG_BAUDi  (cfg_baud),
      .CFG_WEi    (cfg_we),
      .CFG_BUSYo  (cfg_busy),
      .CFG_ERRo   (cfg_err),
      .RX_DONEi   (rx_done),
      .RX_READYi  (rx_ready),
      .RX_DATAi   (rx_data),
      .BAUD_RATEo (baud_rate),
      .BAUD_WEo   (baud_we),
      .BAUD_RDo   (baud_rd),
      .m_if       (m_if.master),
      .OVFo       (ovf),
      .CLR_OVFi   (clr_ovf),
      .FRAME_CNTo (frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

   // Stream monitor: every handshake pops the oldest expected byte.
   always @(negedge clk) begin
      if (rst_n && m_if.M_VALIDo && m_if.M_READYi) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL stream_unexpected: got byte %02h, required none", m_if.M_DATAo);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (m_if.M_DATAo !== e) begin
               failures++;
               $display("FAIL stream_data: got %02h, required %02h", m_if.M_DATAo, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a capture edge and predict whether the buffer accepts it this cycle.
   task automatic send_byte(input logic [7:0] d);
      logic pop_now;
      rx_data = d;
      rx_done = 1'b1;
      pop_now = m_if.M_READYi && (exp_q.size() > 0);
      if (exp_q.size() < DEPTH || pop_now) begin
         exp_q.push_back(d);
         frame_exp++;
      end else begin
         ovf_exp = 1'b1;
      end
   endtask

   task automatic check_load_seq(input logic [31:0] exp_baud);
      logic exp_we, exp_rd, exp_busy;
      for (int i = 0; i < 7; i++) begin
         exp_we   = (i < 3);
         exp_rd   = (i >= 3 && i < 6);
         exp_busy = (i < 6);
         checks++;
         if (baud_we !== exp_we || baud_rd !== exp_rd || cfg_busy !== exp_busy ||
             baud_rate !== exp_baud) begin
            failures++;
            $display("FAIL load_seq[%0d]: we=%b rd=%b busy=%b baud=%0d, required %b %b %b %0d",
                     i, baud_we, baud_rd, cfg_busy, baud_rate, exp_we, exp_rd, exp_busy,
                     exp_baud);
         end
         if (i < 6) tick();
      end
   endtask

   task automatic release_and_load();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (baud_we !== 1'b0 || cfg_busy !== 1'b1) begin
         failures++;
         $display("FAIL init_state: we=%b busy=%b, required 0 1", baud_we, cfg_busy);
      end
      tick();
      check_load_seq(32'd115200);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (baud_rate !== 32'd115200 || baud_we !== 1'b0 || baud_rd !== 1'b0 ||
          m_if.M_VALIDo !== 1'b0 || ovf !== 1'b0 || cfg_err !== 1'b0 ||
          frame_cnt !== 16'd0 || cfg_busy !== 1'b1 || m_if.M_DATAo !== 8'h00) begin
         failures++;
         $display("FAIL reset_values: baud=%0d we=%b rd=%b v=%b ovf=%b err=%b cnt=%0d busy=%b d=%02h",
                  baud_rate, baud_we, baud_rd, m_if.M_VALIDo, ovf, cfg_err, frame_cnt,
                  cfg_busy, m_if.M_DATAo);
      end
      release_and_load();
   endtask

   task automatic test_cfg();
      cfg_baud = 32'd9600;
      cfg_we   = 1'b1;
      rx_ready = 1'b0;
      tick();
      cfg_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (cfg_busy !== 1'b1 || baud_we !== 1'b0 || baud_rate !== 32'd9600) begin
            failures++;
            $display("FAIL pend[%0d]: busy=%b we=%b baud=%0d, required 1 0 9600",
                     i, cfg_busy, baud_we, baud_rate);
         end
         if (i == 4) begin
            cfg_baud = 32'd1234;
            cfg_we   = 1'b1;
         end
         if (i == 5) cfg_we = 1'b0;
         if (i == 9) rx_ready = 1'b1;
         tick();
      end
      check_load_seq(32'd9600);
      cfg_baud = 32'd0;
      cfg_we   = 1'b1;
      tick();
      cfg_we = 1'b0;
      checks++;
      if (cfg_err !== 1'b1 || baud_rate !== 32'd9600 || cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL zero_baud: err=%b baud=%0d busy=%b, required 1 9600 0",
                  cfg_err, baud_rate, cfg_busy);
      end
   endtask

   task automatic test_stream();
      logic [7:0] bytes [2];
      bytes[0] = 8'hA5;
      bytes[1] = 8'h3C;
      m_if.M_READYi = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send_byte(bytes[i]);
         checks++;
         if (m_if.M_VALIDo !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass[%0d]: valid=%b, required 0", i, m_if.M_VALIDo);
         end
         tick();
         rx_done = 1'b0;
         checks++;
         if (m_if.M_VALIDo !== 1'b1 || m_if.M_DATAo !== bytes[i]) begin
            failures++;
            $display("FAIL stream_latency[%0d]: valid=%b data=%02h, required 1 %02h",
                     i, m_if.M_VALIDo, m_if.M_DATAo, bytes[i]);
         end
         tick();
      end
      checks++;
      if (frame_cnt !== 16'(frame_exp) || m_if.M_VALIDo !== 1'b0) begin
         failures++;
         $display("FAIL stream_count: cnt=%0d valid=%b, required %0d 0",
                  frame_cnt, m_if.M_VALIDo, frame_exp);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] head;
      m_if.M_READYi = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         send_byte(8'(i));
         tick();
         rx_done = 1'b0;
         tick();
         if (i > 1) begin
            checks++;
            if (m_if.M_DATAo !== 8'h01) begin
               failures++;
               $display("FAIL hold_stable[%0d]: data=%02h, required 01", i, m_if.M_DATAo);
            end
         end
      end
      checks++;
      if (m_if.M_VALIDo !== 1'b1 || ovf !== ovf_exp || frame_cnt !== 16'(frame_exp)) begin
         failures++;
         $display("FAIL overflow: valid=%b ovf=%b cnt=%0d, required 1 %b %0d",
                  m_if.M_VALIDo, ovf, frame_cnt, ovf_exp, frame_exp);
      end
      // Capture coinciding with a pop while full.
      m_if.M_READYi = 1'b1;
      send_byte(8'h07);
      tick();
      rx_done = 1'b0;
      m_if.M_READYi = 1'b0;
      head = exp_q[0];
      checks++;
      if (ovf !== 1'b1 || frame_cnt !== 16'(frame_exp) || m_if.M_DATAo !== head) begin
         failures++;
         $display("FAIL full_pop_push: ovf=%b cnt=%0d data=%02h, required 1 %0d %02h",
                  ovf, frame_cnt, m_if.M_DATAo, frame_exp, head);
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      ovf_exp = 1'b0;
      checks++;
      if (ovf !== ovf_exp) begin
         failures++;
         $display("FAIL clr_ovf: ovf=%b, required %b", ovf, ovf_exp);
      end
      clr_ovf = 1'b1;
      send_byte(8'h08);
      tick();
      clr_ovf = 1'b0;
      rx_done = 1'b0;
      checks++;
      if (ovf !== ovf_exp || frame_cnt !== 16'(frame_exp)) begin
         failures++;
         $display("FAIL ovf_wins: ovf=%b cnt=%0d, required %b %0d",
                  ovf, frame_cnt, ovf_exp, frame_exp);
      end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      ovf_exp = 1'b0;
   endtask

   task automatic test_back_to_back();
      m_if.M_READYi = 1'b1;
      send_byte(8'h09);
      tick();
      rx_done = 1'b0;
      tick();
      send_byte(8'h0A);
      tick();
      rx_done = 1'b0;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      tick();
      checks++;
      if (exp_q.size() != 0 || m_if.M_VALIDo !== 1'b0 || ovf !== ovf_exp ||
          frame_cnt !== 16'(frame_exp)) begin
         failures++;
         $display("FAIL drain: left=%0d valid=%b ovf=%b cnt=%0d, required 0 0 %b %0d",
                  exp_q.size(), m_if.M_VALIDo, ovf, frame_cnt, ovf_exp, frame_exp);
      end
   endtask

   task automatic test_reset_mid();
      m_if.M_READYi = 1'b0;
      for (int i = 0; i < 2; i++) begin
         send_byte(8'hB0 + 8'(i));
         tick();
         rx_done = 1'b0;
         tick();
      end
      rx_ready = 1'b1;
      cfg_baud = 32'd4800;
      cfg_we   = 1'b1;
      tick();
      cfg_we = 1'b0;
      tick();
      checks++;
      if (baud_we !== 1'b1 || m_if.M_VALIDo !== 1'b1 || baud_rate !== 32'd4800) begin
         failures++;
         $display("FAIL pre_reset: we=%b valid=%b baud=%0d, required 1 1 4800",
                  baud_we, m_if.M_VALIDo, baud_rate);
      end
      rst_n = 1'b0;
      exp_q.delete();
      frame_exp = 0;
      ovf_exp   = 1'b0;
      #1;
      checks++;
      if (m_if.M_VALIDo !== 1'b0 || baud_we !== 1'b0 || baud_rate !== 32'd115200 ||
          frame_cnt !== 16'd0 || cfg_err !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: valid=%b we=%b baud=%0d cnt=%0d err=%b, required 0 0 115200 0 0",
                  m_if.M_VALIDo, baud_we, baud_rate, frame_cnt, cfg_err);
      end
      release_and_load();
   endtask

   initial begin
      m_if.M_READYi = 1'b0;
      test_reset();
      test_cfg();
      test_stream();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
